// File: rtl/spi_xfer_engine.sv
// spi_xfer_engine: SPI master word engine bridging the TX/RX FIFO handshakes and the SPI pins.
//  clk_i/arst_n_i/soft_rst_i          clock, async active-low reset, sync soft reset
//  enable_i/cpol_i/cpha_i/clk_div_i   control, sampled in IDLE and latched on leaving it
//  tx_empty_i/tx_req_o/tx_data_i/tx_resp_i/tx_ack_o   TX FIFO read port
//  rx_full_i/rx_req_o/rx_data_o/rx_ack_i              RX FIFO write port
//  sclk_o/mosi_o/miso_i/ss_n_o        SPI pins
//  busy_o                             high whenever the engine is not idle
module spi_xfer_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  soft_rst_i,
  input  logic                  enable_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic [DIV_WIDTH-1:0]  clk_div_i,
  input  logic                  tx_empty_i,
  output logic                  tx_req_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_resp_i,
  output logic                  tx_ack_o,
  input  logic                  rx_full_i,
  output logic                  rx_req_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  input  logic                  rx_ack_i,
  output logic                  sclk_o,
  output logic                  mosi_o,
  input  logic                  miso_i,
  output logic                  ss_n_o,
  output logic                  busy_o
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] POP   = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] STORE = 3'd4;
  localparam int TW = $clog2(2 * DATA_WIDTH);
  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] sh, cap, cap_nxt;
  logic [DIV_WIDTH-1:0]  div_l, cnt;
  logic [TW-1:0]         tcnt;
  logic                  cpol_l, cpha_l, tgl, go, tick, last, sample;
  assign go      = enable_i & ~tx_empty_i & ~rx_full_i;
  assign tick    = state == SHIFT && cnt == div_l;
  assign last    = tcnt == TW'(2 * DATA_WIDTH - 1);
  // toggle number tcnt+1 is odd when tcnt is even; cpha moves sampling to the even toggles
  assign sample  = ~tcnt[0] ^ cpha_l;
  assign cap_nxt = sample ? {cap[DATA_WIDTH-2:0], miso_i} : cap;
  assign busy_o  = state != IDLE;
  // tgl returns to 0 after the even toggle count, so sclk rests at the latched cpol between words
  assign sclk_o  = busy_o ? cpol_l ^ tgl : cpol_i;
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state     <= IDLE;
      tx_req_o  <= 1'b0;
      tx_ack_o  <= 1'b0;
      rx_req_o  <= 1'b0;
      rx_data_o <= '0;
      mosi_o    <= 1'b0;
      ss_n_o    <= 1'b1;
      sh        <= '0;
      cap       <= '0;
      div_l     <= '0;
      cnt       <= '0;
      tcnt      <= '0;
      cpol_l    <= 1'b0;
      cpha_l    <= 1'b0;
      tgl       <= 1'b0;
    end else if (soft_rst_i) begin
      state     <= IDLE;
      tx_req_o  <= 1'b0;
      tx_ack_o  <= 1'b0;
      rx_req_o  <= 1'b0;
      rx_data_o <= '0;
      mosi_o    <= 1'b0;
      ss_n_o    <= 1'b1;
      sh        <= '0;
      cap       <= '0;
      div_l     <= '0;
      cnt       <= '0;
      tcnt      <= '0;
      cpol_l    <= 1'b0;
      cpha_l    <= 1'b0;
      tgl       <= 1'b0;
    end else begin
      tx_req_o <= 1'b0;
      tx_ack_o <= 1'b0;
      case (state)
        IDLE: if (go) begin
          tx_req_o <= 1'b1;
          cpol_l   <= cpol_i;
          cpha_l   <= cpha_i;
          div_l    <= clk_div_i;
          state    <= FETCH;
        end
        FETCH: if (tx_resp_i) begin
          sh       <= tx_data_i;
          tx_ack_o <= 1'b1;
          ss_n_o   <= 1'b0;
          state    <= POP;
        end
        POP: begin
          cnt   <= '0;
          tcnt  <= '0;
          state <= SHIFT;
          // leading-edge sampling needs the MSB on the wire before the first edge
          if (!cpha_l) begin
            mosi_o <= sh[DATA_WIDTH-1];
            sh     <= {sh[DATA_WIDTH-2:0], 1'b0};
          end
        end
        SHIFT: if (tick) begin
          cnt  <= '0;
          tgl  <= ~tgl;
          tcnt <= tcnt + 1'b1;
          cap  <= cap_nxt;
          if (!sample && !last) begin
            mosi_o <= sh[DATA_WIDTH-1];
            sh     <= {sh[DATA_WIDTH-2:0], 1'b0};
          end
          if (last) begin
            rx_data_o <= cap_nxt;
            rx_req_o  <= 1'b1;
            state     <= STORE;
          end
        end else cnt <= cnt + 1'b1;
        STORE: if (rx_ack_i) begin
          rx_req_o <= 1'b0;
          if (go) begin
            tx_req_o <= 1'b1;
            state    <= FETCH;
          end else begin
            ss_n_o <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_xfer_engine.sv
// tb_spi_xfer_engine: randomized bench with FIFO, RX sink and SPI slave models for spi_xfer_engine.
module tb_spi_xfer_engine;
  logic clk = 0, arst_n = 1, soft_rst = 0, enable = 0, cpol = 0, cpha = 0;
  logic [7:0] clk_div = 0;
  logic tx_empty = 1, tx_req, tx_resp = 0, tx_ack, rx_full = 0, rx_req, rx_ack = 0;
  logic sclk, mosi, miso, ss_n, busy;
  logic [15:0] tx_data = 0, rx_data;
  int n_chk = 0, n_fail = 0;
  logic [15:0] txq[$], sent[$], mosiq[$], exp_rx[$], rxq[$];
  int bursts[$];
  int mode = 0, rdly = 0, adly = 0, n_ack = 0;
  int tog = 0, nsh = 0, wcnt = 0, rcnt = 0, lowcnt = 0;
  bit pend = 0, have = 0, preq = 0;
  logic [15:0] sw = 0, mbits = 0, hold = 0;
  logic sbit = 0, psclk = 0, pmosi = 0, pss = 1;

  always #5 clk = ~clk;
  // mode 0: loopback, mode 1: random slave word, mode 2: MISO tied high
  assign miso = mode == 0 ? mosi : sbit;

  spi_xfer_engine #(.DATA_WIDTH(16), .DIV_WIDTH(8)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .soft_rst_i(soft_rst), .enable_i(enable),
    .cpol_i(cpol), .cpha_i(cpha), .clk_div_i(clk_div), .tx_empty_i(tx_empty),
    .tx_req_o(tx_req), .tx_data_i(tx_data), .tx_resp_i(tx_resp), .tx_ack_o(tx_ack),
    .rx_full_i(rx_full), .rx_req_o(rx_req), .rx_data_o(rx_data), .rx_ack_i(rx_ack),
    .sclk_o(sclk), .mosi_o(mosi), .miso_i(miso), .ss_n_o(ss_n), .busy_o(busy)
  );

  function automatic logic [15:0] at(input logic [15:0] q[$], input int i);
    return i < q.size() ? q[i] : 16'h0;
  endfunction

  // TX FIFO, RX sink and SPI slave models, sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    int idx;
    bit tg, smp;
    int tb4;
    #1;
    if (!arst_n) begin
      pend = 0; tx_resp = 0; rx_ack = 0; wcnt = 0; preq = 0;
    end else begin
      if (tx_req) begin
        n_chk++;
        if (tx_empty) begin n_fail++; $display("FAIL tx_req_empty: tx_req=1 while tx_empty=1"); end
        n_chk++;
        if (rx_req) begin n_fail++; $display("FAIL fetch_before_ack: tx_req=1 while rx_req=1"); end
        n_chk++;
        if (preq) begin n_fail++; $display("FAIL tx_req_pulse: tx_req high 2 cycles, expected 1"); end
        pend = 1; rcnt = rdly;
      end
      preq = tx_req;
      if (tx_ack) begin
        n_ack++;
        n_chk++;
        if (!tx_resp) begin n_fail++; $display("FAIL ack_without_resp: tx_ack=1 with tx_resp=0"); end
        if (txq.size() > 0) sent.push_back(txq.pop_front());
        tx_resp = 0;
      end else if (pend) begin
        if (rcnt == 0) begin
          pend = 0; tx_resp = 1; tx_data = txq.size() > 0 ? txq[0] : 16'hDEAD;
        end else rcnt--;
      end
      tx_empty = txq.size() == 0;
      if (rx_ack) begin
        rx_ack = 0;
        n_chk++;
        if (rx_req) begin n_fail++; $display("FAIL rx_req_after_ack: rx_req=1, expected 0"); end
      end else if (rx_req) begin
        if (wcnt == 0) hold = rx_data;
        else begin
          n_chk++;
          if (rx_data !== hold) begin n_fail++; $display("FAIL rx_data_stable: got %h expected %h", rx_data, hold); end
        end
        if (wcnt == adly) begin rx_ack = 1; rxq.push_back(rx_data); wcnt = 0; end
        else wcnt++;
      end
    end
    tg = sclk !== psclk;
    if (ss_n) begin
      tog = 0; nsh = 0; have = 0;
    end else begin
      if (!have) begin
        have = 1;
        sw = mode == 2 ? 16'hFFFF : 16'($urandom);
        sbit = cpha ? 1'b0 : sw[15];
      end
      tb4 = tog;
      smp = 0;
      if (tg) begin
        tog++;
        smp = cpha ? (tog % 2 == 0) : (tog % 2 == 1);
        if (smp) mbits = {mbits[14:0], mosi};
        else begin
          nsh++;
          idx = cpha ? nsh - 1 : nsh;
          sbit = (idx >= 0 && idx < 16) ? sw[15-idx] : 1'b0;
        end
      end
      if (tb4 > 0 && mosi !== pmosi) begin
        n_chk++;
        if (!(tg && !smp)) begin n_fail++; $display("FAIL mosi_edge: mosi changed at toggle %0d, expected only on shift toggles", tog); end
      end
      if (tog == 32) begin
        mosiq.push_back(mbits);
        exp_rx.push_back(mode == 0 ? mbits : sw);
        tog = 0; nsh = 0; have = 0;
      end
    end
    if (tog == 0) begin
      n_chk++;
      if (sclk !== cpol) begin n_fail++; $display("FAIL sclk_idle: got %b expected %b", sclk, cpol); end
    end
    if (!ss_n) lowcnt++;
    if (ss_n && !pss) begin bursts.push_back(lowcnt); lowcnt = 0; end
    psclk = sclk; pmosi = mosi; pss = ss_n;
  end

  task automatic clr();
    txq.delete(); sent.delete(); mosiq.delete(); exp_rx.delete(); rxq.delete(); bursts.delete();
    n_ack = 0; lowcnt = 0;
  endtask

  task automatic xfer(input int m, input logic p, input logic h, input logic [7:0] d,
                      input int a, input int r, output bit done);
    int n;
    n = txq.size();
    @(negedge clk);
    mode = m; cpol = p; cpha = h; clk_div = d; adly = a; rdly = r; enable = 1;
    done = 0;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      done = rxq.size() == n && !busy && bursts.size() > 0;
    end
    enable = 0;
  endtask

  task automatic test_reset();
    #1 arst_n = 0; cpol = 1;
    #2;
    n_chk++; if (tx_req !== 0 || tx_ack !== 0 || rx_req !== 0) begin n_fail++; $display("FAIL reset_handshake: req/ack/req=%b%b%b expected 000", tx_req, tx_ack, rx_req); end
    n_chk++; if (rx_data !== 16'h0) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 0000", rx_data); end
    n_chk++; if (ss_n !== 1 || busy !== 0 || mosi !== 0) begin n_fail++; $display("FAIL reset_pins: ss_n/busy/mosi=%b%b%b expected 100", ss_n, busy, mosi); end
    n_chk++; if (sclk !== 1) begin n_fail++; $display("FAIL reset_sclk_cpol1: got %b expected 1", sclk); end
    cpol = 0;
    #1;
    n_chk++; if (sclk !== 0) begin n_fail++; $display("FAIL reset_sclk_cpol0: got %b expected 0", sclk); end
    repeat (2) @(negedge clk);
    arst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0();
    bit done;
    clr(); txq.push_back(16'hA5C3);
    xfer(0, 0, 0, 8'd1, 0, 0, done);
    n_chk++; if (!done) begin n_fail++; $display("FAIL t1_timeout: transfer did not finish"); end
    n_chk++; if (rxq.size() != 1) begin n_fail++; $display("FAIL t1_push_count: got %0d expected 1", rxq.size()); end
    n_chk++; if (at(rxq, 0) !== 16'hA5C3) begin n_fail++; $display("FAIL t1_rx_data: got %h expected a5c3", at(rxq, 0)); end
    n_chk++; if (at(mosiq, 0) !== 16'hA5C3) begin n_fail++; $display("FAIL t1_mosi: got %h expected a5c3", at(mosiq, 0)); end
    n_chk++; if (n_ack != 1) begin n_fail++; $display("FAIL t1_ack_count: got %0d expected 1", n_ack); end
    n_chk++; if (bursts.size() != 1 || bursts[0] != 66) begin n_fail++; $display("FAIL t1_ss_low: got %0d cycles expected 66", bursts.size() ? bursts[0] : -1); end
  endtask

  task automatic test_mode3();
    bit done;
    clr(); txq.push_back(16'($urandom));
    xfer(2, 1, 1, 8'd0, 0, 0, done);
    n_chk++; if (!done) begin n_fail++; $display("FAIL t2_timeout: transfer did not finish"); end
    n_chk++; if (at(rxq, 0) !== 16'hFFFF) begin n_fail++; $display("FAIL t2_rx_data: got %h expected ffff", at(rxq, 0)); end
    n_chk++; if (at(mosiq, 0) !== at(sent, 0)) begin n_fail++; $display("FAIL t2_mosi: got %h expected %h", at(mosiq, 0), at(sent, 0)); end
    n_chk++; if (bursts.size() != 1 || bursts[0] != 34) begin n_fail++; $display("FAIL t2_ss_low: got %0d cycles expected 34", bursts.size() ? bursts[0] : -1); end
    n_chk++; if (sclk !== 1) begin n_fail++; $display("FAIL t2_sclk_idle: got %b expected 1", sclk); end
  endtask

  task automatic test_back_to_back();
    bit done;
    clr();
    for (int i = 0; i < 3; i++) txq.push_back(16'($urandom));
    xfer(1, 0, 1, 8'd2, 0, 0, done);
    n_chk++; if (!done) begin n_fail++; $display("FAIL t3_timeout: transfer did not finish"); end
    n_chk++; if (n_ack != 3 || rxq.size() != 3) begin n_fail++; $display("FAIL t3_counts: acks %0d pushes %0d expected 3 3", n_ack, rxq.size()); end
    n_chk++; if (bursts.size() != 1 || bursts[0] != 3 * (2 + 96) + 2) begin n_fail++; $display("FAIL t3_ss_low: got %0d bursts first %0d expected 1 burst of %0d", bursts.size(), bursts.size() ? bursts[0] : -1, 3 * 98 + 2); end
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (at(rxq, i) !== at(exp_rx, i)) begin n_fail++; $display("FAIL t3_rx_%0d: got %h expected %h", i, at(rxq, i), at(exp_rx, i)); end
      n_chk++; if (at(mosiq, i) !== at(sent, i)) begin n_fail++; $display("FAIL t3_mosi_%0d: got %h expected %h", i, at(mosiq, i), at(sent, i)); end
    end
  endtask

  task automatic test_ack_delay();
    bit done;
    clr();
    for (int i = 0; i < 2; i++) txq.push_back(16'($urandom));
    xfer(1, 1, 0, 8'd1, 5, 1, done);
    n_chk++; if (!done) begin n_fail++; $display("FAIL t4_timeout: transfer did not finish"); end
    n_chk++; if (rxq.size() != 2) begin n_fail++; $display("FAIL t4_push_count: got %0d expected 2", rxq.size()); end
    n_chk++; if (bursts.size() != 1 || bursts[0] != 2 * (2 + 64 + 5) + 2) begin n_fail++; $display("FAIL t4_ss_low: got %0d expected %0d", bursts.size() ? bursts[0] : -1, 2 * 71 + 2); end
    for (int i = 0; i < 2; i++) begin
      n_chk++; if (at(rxq, i) !== at(exp_rx, i)) begin n_fail++; $display("FAIL t4_rx_%0d: got %h expected %h", i, at(rxq, i), at(exp_rx, i)); end
    end
  endtask

  task automatic test_soft_reset();
    bit done;
    logic [15:0] w;
    clr(); txq.push_back(16'($urandom));
    @(negedge clk);
    mode = 1; cpol = 1; cpha = 0; clk_div = 8'd1; adly = 0; rdly = 0; enable = 1;
    for (int c = 0; c < 2000 && tog < 15; c++) @(negedge clk);
    enable = 0;
    n_chk++; if (tog < 15) begin n_fail++; $display("FAIL t5_reach: toggle count %0d expected 15", tog); end
    soft_rst = 1;
    @(posedge clk); #1;
    n_chk++; if (ss_n !== 1 || busy !== 0) begin n_fail++; $display("FAIL t5_abort: ss_n/busy=%b%b expected 10", ss_n, busy); end
    n_chk++; if (sclk !== 1) begin n_fail++; $display("FAIL t5_sclk: got %b expected 1", sclk); end
    n_chk++; if (rx_req !== 0) begin n_fail++; $display("FAIL t5_rx_req: got %b expected 0", rx_req); end
    @(negedge clk); soft_rst = 0;
    repeat (40) @(negedge clk);
    n_chk++; if (rxq.size() != 0 || busy) begin n_fail++; $display("FAIL t5_no_push: pushes %0d busy %b expected 0 0", rxq.size(), busy); end
    clr(); w = 16'($urandom); txq.push_back(w);
    xfer(0, 0, 0, 8'd1, 0, 0, done);
    n_chk++; if (!done || at(rxq, 0) !== w) begin n_fail++; $display("FAIL t5_restart: got %h expected %h", at(rxq, 0), w); end
  endtask

  task automatic test_async_reset();
    bit done;
    logic [15:0] w;
    clr(); w = 16'($urandom); txq.push_back(w);
    @(negedge clk);
    mode = 0; cpol = 1; cpha = 0; clk_div = 8'd0; rdly = 10; adly = 0; enable = 1;
    for (int c = 0; c < 100 && !busy; c++) @(negedge clk);
    n_chk++; if (!busy) begin n_fail++; $display("FAIL t6_fetch: busy=%b expected 1", busy); end
    @(negedge clk);
    #1 arst_n = 0;
    #1;
    n_chk++; if (tx_req !== 0 || tx_ack !== 0 || rx_req !== 0) begin n_fail++; $display("FAIL t6_handshake: req/ack/req=%b%b%b expected 000", tx_req, tx_ack, rx_req); end
    n_chk++; if (rx_data !== 16'h0) begin n_fail++; $display("FAIL t6_rx_data: got %h expected 0000", rx_data); end
    n_chk++; if (ss_n !== 1 || busy !== 0 || mosi !== 0 || sclk !== 1) begin n_fail++; $display("FAIL t6_pins: ss_n/busy/mosi/sclk=%b%b%b%b expected 1001", ss_n, busy, mosi, sclk); end
    enable = 0;
    repeat (3) @(negedge clk);
    arst_n = 1;
    repeat (2) @(negedge clk);
    n_chk++; if (n_ack != 0) begin n_fail++; $display("FAIL t6_ack: got %0d pulses expected 0", n_ack); end
    clr(); txq.push_back(w);
    xfer(0, 1, 0, 8'd0, 0, 0, done);
    n_chk++; if (!done || at(rxq, 0) !== w || n_ack != 1) begin n_fail++; $display("FAIL t6_restart: got %h acks %0d expected %h 1", at(rxq, 0), n_ack, w); end
  endtask

  task automatic test_rx_full();
    bit done;
    clr(); txq.push_back(16'($urandom));
    @(negedge clk);
    rx_full = 1; mode = 0; rdly = 0; adly = 0; enable = 1;
    repeat (30) @(negedge clk);
    n_chk++; if (busy || n_ack != 0) begin n_fail++; $display("FAIL rx_full_block: busy %b acks %0d expected 0 0", busy, n_ack); end
    enable = 0; rx_full = 0;
    xfer(0, 0, 1, 8'd0, 1, 0, done);
    n_chk++; if (!done || at(rxq, 0) !== at(sent, 0)) begin n_fail++; $display("FAIL rx_full_resume: got %h expected %h", at(rxq, 0), at(sent, 0)); end
  endtask

  task automatic test_random();
    bit done, p, h;
    int n, m, d, a, r, low;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 3); m = $urandom_range(0, 1); d = $urandom_range(0, 3);
      a = $urandom_range(0, 3); r = $urandom_range(0, 2);
      p = 1'($urandom); h = 1'($urandom);
      clr();
      for (int i = 0; i < n; i++) txq.push_back(16'($urandom));
      xfer(m, p, h, 8'(d), a, r, done);
      low = n * (2 + 32 * (d + 1) + a) + (n - 1) * (1 + r);
      n_chk++; if (!done) begin n_fail++; $display("FAIL rnd%0d_timeout: transfer did not finish", it); end
      n_chk++; if (bursts.size() != 1 || bursts[0] != low) begin n_fail++; $display("FAIL rnd%0d_ss_low: got %0d expected %0d", it, bursts.size() ? bursts[0] : -1, low); end
      n_chk++; if (rxq.size() != n || n_ack != n) begin n_fail++; $display("FAIL rnd%0d_counts: pushes %0d acks %0d expected %0d", it, rxq.size(), n_ack, n); end
      for (int i = 0; i < n; i++) begin
        n_chk++; if (at(rxq, i) !== at(exp_rx, i)) begin n_fail++; $display("FAIL rnd%0d_rx_%0d: got %h expected %h", it, i, at(rxq, i), at(exp_rx, i)); end
        n_chk++; if (at(mosiq, i) !== at(sent, i)) begin n_fail++; $display("FAIL rnd%0d_mosi_%0d: got %h expected %h", it, i, at(mosiq, i), at(sent, i)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_back_to_back();
    test_ack_delay();
    test_soft_reset();
    test_async_reset();
    test_rx_full();
    test_random();
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
